// File: rtl/game_pkg.sv
// Shared game constants: FSM state codes, direction codes and the default
// two-player keyboard map consumed by the operation encoder.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTING   = 3'd1,
        ST_SYNCING   = 3'd2,
        ST_COUNTDOWN = 3'd3,
        ST_RACING    = 3'd4,
        ST_PAUSE     = 3'd5,
        ST_FINISH    = 3'd6
    } game_state_e;

    localparam logic [1:0] H_NIL   = 2'd0;
    localparam logic [1:0] H_LEFT  = 2'd1;
    localparam logic [1:0] H_RIGHT = 2'd2;
    localparam logic [1:0] V_NIL   = 2'd0;
    localparam logic [1:0] V_UP    = 2'd1;
    localparam logic [1:0] V_DOWN  = 2'd2;

    localparam int SCAN_W     = 9;
    localparam int KEYS_W     = 6 * SCAN_W;
    localparam int MAX_PLAYER = 4;
    localparam int KEYMAP_W   = MAX_PLAYER * KEYS_W;

    // Slot order inside one player's packed key set
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_BOOST = 4;
    localparam int KEY_HONK  = 5;

    function automatic logic [KEYS_W-1:0] pack_keys(
        input logic [SCAN_W-1:0] up,
        input logic [SCAN_W-1:0] left,
        input logic [SCAN_W-1:0] down,
        input logic [SCAN_W-1:0] right,
        input logic [SCAN_W-1:0] boost,
        input logic [SCAN_W-1:0] honk
    );
        return {honk, boost, right, down, left, up};
    endfunction

    localparam logic [KEYMAP_W-1:0] KEYMAP_DEFAULT = {
        {KEYS_W{1'b0}},
        {KEYS_W{1'b0}},
        pack_keys(9'h043, 9'h03B, 9'h042, 9'h04B, 9'h059, 9'h070),
        pack_keys(9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h012, 9'h029)
    };

endpackage

// File: rtl/multi_player_op_encoder_if.sv
// Bundle between keyboard decoder / game FSM and the per-player operation encoder.
interface multi_player_op_encoder_if #(
    parameter int NUM_PLAYERS = 2
) ();
    logic [511:0]               key_down;
    logic [8:0]                 last_change;
    logic                       key_valid;
    logic [2:0]                 state;
    logic [2*NUM_PLAYERS-1:0]   h_code;
    logic [2*NUM_PLAYERS-1:0]   v_code;
    logic [NUM_PLAYERS-1:0]     boost;
    logic [NUM_PLAYERS-1:0]     honk;
    logic [8*NUM_PLAYERS-1:0]   boost_level;

    modport master (
        output key_down, last_change, key_valid, state,
        input  h_code, v_code, boost, honk, boost_level
    );

    modport slave (
        input  key_down, last_change, key_valid, state,
        output h_code, v_code, boost, honk, boost_level
    );
endinterface

// File: rtl/op_encoder_lane.sv
// One cart's controls: axis resolution with last-pressed priority, boost meter
// with refill divider, and edge-triggered honk with cooldown.
module op_encoder_lane
    import game_pkg::*;
#(
    parameter logic [KEYS_W-1:0] KEYS = KEYMAP_DEFAULT[KEYS_W-1:0],
    parameter int BOOST_MAX     = 255,
    parameter int REFILL_DIV    = 4,
    parameter int HONK_COOLDOWN = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic [2:0]   state,
    output logic [1:0]   h_code,
    output logic [1:0]   v_code,
    output logic         boost,
    output logic         honk,
    output logic [7:0]   boost_level
);
    localparam logic [8:0] K_UP    = KEYS[KEY_UP*SCAN_W    +: SCAN_W];
    localparam logic [8:0] K_LEFT  = KEYS[KEY_LEFT*SCAN_W  +: SCAN_W];
    localparam logic [8:0] K_DOWN  = KEYS[KEY_DOWN*SCAN_W  +: SCAN_W];
    localparam logic [8:0] K_RIGHT = KEYS[KEY_RIGHT*SCAN_W +: SCAN_W];
    localparam logic [8:0] K_BOOST = KEYS[KEY_BOOST*SCAN_W +: SCAN_W];
    localparam logic [8:0] K_HONK  = KEYS[KEY_HONK*SCAN_W  +: SCAN_W];

    localparam int DIV_W = (REFILL_DIV > 1) ? $clog2(REFILL_DIV) : 1;
    localparam int CD_W  = (HONK_COOLDOWN > 0) ? $clog2(HONK_COOLDOWN + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFILL_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(HONK_COOLDOWN);
    localparam logic [7:0]       METER_MAX = 8'(BOOST_MAX);

    function automatic logic [7:0] meter_inc(input logic [7:0] m);
        return (m >= METER_MAX) ? METER_MAX : m + 8'd1;
    endfunction

    function automatic logic [7:0] meter_dec(input logic [7:0] m);
        return (m == 8'd0) ? 8'd0 : m - 8'd1;
    endfunction

    function automatic logic [CD_W-1:0] cd_dec(input logic [CD_W-1:0] c);
        return (c == '0) ? '0 : c - CD_W'(1);
    endfunction

    logic             h_last, v_last, honk_prev;
    logic [7:0]       meter;
    logic [DIV_W-1:0] div_cnt;
    logic [CD_W-1:0]  cd;
    logic [1:0]       h_code_p1, v_code_p1;
    logic             boost_p1, honk_p1;

    logic             racing, paused, key_evt;
    logic             h_last_nxt, v_last_nxt;
    logic [1:0]       h_res, v_res;
    logic             boost_nxt, honk_nxt;
    logic [7:0]       meter_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [CD_W-1:0]  cd_nxt;

    // Stage p0: decode the current inputs into next control/meter values
    always_comb begin
        racing     = (state == ST_RACING);
        paused     = (state == ST_PAUSE);
        key_evt    = key_valid && key_down[last_change];
        h_last_nxt = h_last;
        v_last_nxt = v_last;
        h_res      = H_NIL;
        v_res      = V_NIL;
        meter_nxt  = meter;
        div_nxt    = div_cnt;
        cd_nxt     = cd;

        // A press in this very cycle already decides a two-key tie
        if (key_evt && last_change == K_LEFT)       h_last_nxt = 1'b0;
        else if (key_evt && last_change == K_RIGHT) h_last_nxt = 1'b1;
        if (key_evt && last_change == K_UP)         v_last_nxt = 1'b0;
        else if (key_evt && last_change == K_DOWN)  v_last_nxt = 1'b1;

        if (racing) begin
            unique case ({key_down[K_LEFT], key_down[K_RIGHT]})
                2'b10:   h_res = H_LEFT;
                2'b01:   h_res = H_RIGHT;
                2'b11:   h_res = h_last_nxt ? H_RIGHT : H_LEFT;
                default: h_res = H_NIL;
            endcase
            unique case ({key_down[K_UP], key_down[K_DOWN]})
                2'b10:   v_res = V_UP;
                2'b01:   v_res = V_DOWN;
                2'b11:   v_res = v_last_nxt ? V_DOWN : V_UP;
                default: v_res = V_NIL;
            endcase
        end

        boost_nxt = racing && key_down[K_BOOST] && (h_res != H_NIL || v_res != V_NIL)
                    && (meter != 8'd0);
        honk_nxt  = racing && key_down[K_HONK] && !honk_prev && (cd == '0);

        if (racing) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (boost_nxt)                meter_nxt = meter_dec(meter);
            else if (div_cnt == DIV_LAST) meter_nxt = meter_inc(meter);
            cd_nxt = honk_nxt ? CD_LOAD : cd_dec(cd);
        end else if (!paused) begin
            meter_nxt = METER_MAX;
            div_nxt   = '0;
            cd_nxt    = '0;
        end
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            h_last    <= 1'b0;
            v_last    <= 1'b0;
            honk_prev <= 1'b0;
            meter     <= METER_MAX;
            div_cnt   <= '0;
            cd        <= '0;
            h_code_p1 <= H_NIL;
            v_code_p1 <= V_NIL;
            boost_p1  <= 1'b0;
            honk_p1   <= 1'b0;
        end else begin
            h_last    <= h_last_nxt;
            v_last    <= v_last_nxt;
            honk_prev <= key_down[K_HONK];
            meter     <= meter_nxt;
            div_cnt   <= div_nxt;
            cd        <= cd_nxt;
            h_code_p1 <= h_res;
            v_code_p1 <= v_res;
            boost_p1  <= boost_nxt;
            honk_p1   <= honk_nxt;
        end
    end

    assign h_code      = h_code_p1;
    assign v_code      = v_code_p1;
    assign boost       = boost_p1;
    assign honk        = honk_p1;
    assign boost_level = meter;

endmodule

// File: rtl/multi_player_op_encoder.sv
// Turns held-key bitmap and key events into per-cart direction, boost and honk
// controls; one independent lane per player.
module multi_player_op_encoder
    import game_pkg::*;
#(
    parameter int                    NUM_PLAYERS   = 2,
    parameter logic [KEYMAP_W-1:0]   KEYMAP        = KEYMAP_DEFAULT,
    parameter int                    BOOST_MAX     = 255,
    parameter int                    REFILL_DIV    = 4,
    parameter int                    HONK_COOLDOWN = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_player_op_encoder_if.slave bus
);
    logic [2*NUM_PLAYERS-1:0] h_all, v_all;
    logic [NUM_PLAYERS-1:0]   boost_all, honk_all;
    logic [8*NUM_PLAYERS-1:0] level_all;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        op_encoder_lane #(
            .KEYS          (KEYMAP[p*KEYS_W +: KEYS_W]),
            .BOOST_MAX     (BOOST_MAX),
            .REFILL_DIV    (REFILL_DIV),
            .HONK_COOLDOWN (HONK_COOLDOWN)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .key_down    (bus.key_down),
            .last_change (bus.last_change),
            .key_valid   (bus.key_valid),
            .state       (bus.state),
            .h_code      (h_all[2*p +: 2]),
            .v_code      (v_all[2*p +: 2]),
            .boost       (boost_all[p]),
            .honk        (honk_all[p]),
            .boost_level (level_all[8*p +: 8])
        );
    end

    assign bus.h_code      = h_all;
    assign bus.v_code      = v_all;
    assign bus.boost       = boost_all;
    assign bus.honk        = honk_all;
    assign bus.boost_level = level_all;

endmodule
